// File: rtl/ffi_pkg.sv
// Shared types and width helpers for the feedforward-inhibition gamma scheduler.
// Holds the scheduler state encoding and the count-width function used by every count.
package ffi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    REST = 2'd2
  } state_t;

  // Bits needed to hold any count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ffi_admit.sv
// Admission filter: picks which candidate lines fit the remaining budget (purely combinational).
// FFI_PARTIAL_ADMIT_EN: keep the lowest-index lines that fit; otherwise an oversize step admits nothing.
module ffi_admit
  import ffi_pkg::*;
#(
  parameter int NUM_SPIKES = 8,
  parameter int CW         = cnt_width(NUM_SPIKES)
) (
  input  logic [NUM_SPIKES-1:0] cand,
  input  logic [CW-1:0]         room,
  output logic [NUM_SPIKES-1:0] admit,
  output logic [CW-1:0]         admit_cnt
);

  logic [CW-1:0] n;

  always_comb begin
    n = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      n = n + CW'(cand[i]);
    end
  end

`ifdef FFI_PARTIAL_ADMIT_EN
  logic [CW-1:0] taken;

  always_comb begin
    admit = '0;
    taken = '0;
    if (n <= room) begin
      admit = cand;
    end else begin
      for (int i = 0; i < NUM_SPIKES; i++) begin
        if (cand[i] && (taken < room)) begin
          admit[i] = 1'b1;
          taken    = taken + CW'(1);
        end
      end
    end
  end
`else
  assign admit = (n <= room) ? cand : '0;
`endif

  always_comb begin
    admit_cnt = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      admit_cnt = admit_cnt + CW'(admit[i]);
    end
  end

endmodule

// File: rtl/ffi_gamma_ctrl.sv
// Gamma-cycle FFI scheduler; FFI_PARTIAL_ADMIT_EN selects truncating admission over whole-step rejection.
// spike_out lands 1 cycle after a valid step; no backpressure, every spike_valid in RUN is consumed.
`ifndef FFI_NUM_SPIKES
`define FFI_NUM_SPIKES 8
`endif
`ifndef FFI_MAX_SPIKES
`define FFI_MAX_SPIKES 3
`endif

module ffi_gamma_ctrl
  import ffi_pkg::*;
#(
  parameter int NUM_SPIKES = `FFI_NUM_SPIKES,
  parameter int FFI_MAX    = `FFI_MAX_SPIKES,
  parameter int GAMMA_LEN  = 8,
  parameter int REST_LEN   = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               spike_valid,
  input  logic [NUM_SPIKES-1:0]              spike_in_l,
  output logic [NUM_SPIKES-1:0]              spike_out,
  output logic                               spike_out_valid,
  output logic [NUM_SPIKES-1:0]              fired,
  output logic [cnt_width(NUM_SPIKES)-1:0]   spike_count,
  output logic                               busy,
  output logic                               done
);

  localparam int CW      = cnt_width(NUM_SPIKES);
  // A budget at or above the line count can never bind, so clamp it to what fits in CW bits.
  localparam int EFF_MAX = (FFI_MAX < NUM_SPIKES) ? FFI_MAX : NUM_SPIKES;
  localparam int SW      = (GAMMA_LEN > 1) ? $clog2(GAMMA_LEN) : 1;
  localparam int RW      = (REST_LEN > 1) ? $clog2(REST_LEN) : 1;

  localparam logic [CW-1:0] MAX_CNT   = CW'(EFF_MAX);
  localparam logic [SW-1:0] STEP_LAST = SW'(GAMMA_LEN - 1);
  localparam logic [RW-1:0] REST_LAST = RW'(REST_LEN - 1);

  state_t                  state_q, state_d;
  logic [SW-1:0]           step_q;
  logic [RW-1:0]           rest_q;
  logic                    start_ok, step_ok, rest_last;
  logic [NUM_SPIKES-1:0]   cand, admit;
  logic [CW-1:0]           room, admit_cnt;

`ifdef FFI_PARTIAL_ADMIT_EN
  assign cand = ~spike_in_l & ~fired;
`else
  // Once a step has been rejected the cycle stays inhibited until the next start.
  logic inhibit_q;
  assign cand = ~spike_in_l & ~fired & {NUM_SPIKES{~inhibit_q}};
`endif

  assign room = MAX_CNT - spike_count;
  assign busy = (state_q != IDLE);

  ffi_admit #(
    .NUM_SPIKES (NUM_SPIKES),
    .CW         (CW)
  ) u_admit (
    .cand      (cand),
    .room      (room),
    .admit     (admit),
    .admit_cnt (admit_cnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    step_ok   = 1'b0;
    rest_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          start_ok = 1'b1;
        end
      end
      RUN: begin
        if (spike_valid) begin
          step_ok = 1'b1;
          if (step_q == STEP_LAST) begin
            state_d = REST;
          end
        end
      end
      REST: begin
        if (rest_q == REST_LAST) begin
          state_d   = IDLE;
          rest_last = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spike_out       <= '0;
      spike_out_valid <= 1'b0;
      fired           <= '0;
      spike_count     <= '0;
      done            <= 1'b0;
      step_q          <= '0;
      rest_q          <= '0;
`ifndef FFI_PARTIAL_ADMIT_EN
      inhibit_q       <= 1'b0;
`endif
    end else begin
      spike_out       <= step_ok ? admit : '0;
      spike_out_valid <= step_ok;
      done            <= rest_last;
      if (start_ok || rest_last) begin
        fired       <= '0;
        spike_count <= '0;
        step_q      <= '0;
        rest_q      <= '0;
`ifndef FFI_PARTIAL_ADMIT_EN
        inhibit_q   <= 1'b0;
`endif
      end else if (step_ok) begin
        fired       <= fired | admit;
        spike_count <= spike_count + admit_cnt;
        step_q      <= step_q + SW'(1);
        rest_q      <= '0;
`ifndef FFI_PARTIAL_ADMIT_EN
        if ((cand != '0) && (admit == '0)) begin
          inhibit_q <= 1'b1;
        end
`endif
      end else if (state_q == REST) begin
        rest_q <= rest_q + RW'(1);
      end
    end
  end

endmodule

// File: doc/ffi_gamma_ctrl.md
# ffi_gamma_ctrl

Gamma-cycle scheduler for feedforward inhibition in the spiking column. It sequences one gamma cycle of GAMMA_LEN time steps and takes an active-low spike vector per step. It admits each line at most once per cycle. It enforces a cumulative budget of FFI_MAX admitted spikes per cycle, then holds a rest window that clears per-cycle state before the next cycle.

## Interface
Parameters:
- NUM_SPIKES, default `` `num_spikes ``: number of spike lines.
- FFI_MAX, default `` `ffi_max ``: maximum admitted spikes per gamma cycle.
- GAMMA_LEN, default 8: valid steps per gamma cycle, minimum 1.
- REST_LEN, default 2: rest cycles after the last step, minimum 1.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high; clears all state.
- start, in, 1: begin a gamma cycle; honoured only in IDLE.
- spike_valid, in, 1: spike_in_l carries a valid step this cycle.
- spike_in_l, in, NUM_SPIKES: active-low spike per line.
- spike_out, out, NUM_SPIKES: active-high admitted spikes, registered.
- spike_out_valid, out, 1: spike_out holds a processed step.
- fired, out, NUM_SPIKES: sticky mask of lines admitted this gamma cycle.
- spike_count, out, $clog2(NUM_SPIKES+1): admitted spikes this cycle, saturates at FFI_MAX.
- busy, out, 1: high in RUN and REST.
- done, out, 1: one-cycle pulse when the rest window ends.

## Operation
States and transitions:
- IDLE: start → RUN; step counter, fired and spike_count are cleared.
- RUN: each valid step advances the step counter. On the valid step where the counter equals GAMMA_LEN-1 → REST.
- REST: counts REST_LEN cycles. On the last one → IDLE with done=1; fired and spike_count clear on that same edge.

Per valid step in RUN:
- cand = ~spike_in_l & ~fired.
- n = popcount(cand).
- room = FFI_MAX - spike_count.

Admission:
- n ≤ room: admit all of cand.
- n > room: behaviour set by the macro (see Configuration).
- spike_count = FFI_MAX: nothing admitted for the rest of the cycle; steps are still counted.

On every valid step:
- Admitted lines are ORed into fired.
- spike_count += popcount(admitted).

Boundary conditions:
- spike_valid low in RUN: no step counted; spike_out_valid=0 next cycle.
- spike_valid or start outside the accepting state is ignored: spike_valid outside RUN, start outside IDLE.
- start and spike_valid in the same IDLE cycle: that step is not processed.
- All popcount and count arithmetic uses $clog2(NUM_SPIKES+1) bits, so n = NUM_SPIKES does not overflow.
- FFI_MAX ≥ NUM_SPIKES makes the budget unreachable.
- Reset mid-RUN or mid-REST: immediate return to IDLE, all outputs 0, no done pulse.

## Timing
- Reset value of every output is 0; state resets to IDLE.
- Latency from a valid step to its spike_out/spike_out_valid is 1 cycle.
- fired and spike_count update on the same edge as spike_out.
- spike_out is 0 whenever spike_out_valid is 0.
- busy rises the cycle after start is accepted and falls together with done.
- Minimum cycle from start to done: 1 + GAMMA_LEN + REST_LEN cycles with spike_valid held high.
- Back-to-back: start is accepted in the cycle after done.

## Configuration
Macro: FFI_PARTIAL_ADMIT_EN.
- Defined: when n > room, the room lowest-index lines of cand are admitted and the rest inhibited; spike_count reaches FFI_MAX.
- Not defined: when n > room, the whole step is rejected and spike_count is unchanged. The cycle is marked inhibited: no further admissions until REST, even if later steps would fit.

## Structure
- Shared package ffi_pkg holds:
  - the state enum (IDLE, RUN, REST);
  - the count-width function clog2(NUM_SPIKES+1).
- Counts and comparisons use the package function.
- Sub-module ffi_admit (combinational) takes cand and room and returns the admitted mask and its popcount. The truncation path inside ffi_admit is compiled only under FFI_PARTIAL_ADMIT_EN.

## Test plan
Bench parameters: NUM_SPIKES=8, FFI_MAX=3, GAMMA_LEN=4, REST_LEN=2.
- Reset asserted mid-stream → all outputs 0, busy=0; start the following cycle is accepted.
- start, then step spike_in_l=8'hFC → next cycle spike_out=8'h03, spike_out_valid=1, spike_count=2, fired=8'h03.
- Following step spike_in_l=8'hF0 (cand=8'h0C, room=1):
  - with macro: spike_out=8'h04, spike_count=3;
  - without: spike_out=8'h00, spike_count=2, and a later step 8'hEF also gives spike_out=8'h00.
- Repeat of an already-fired line, spike_in_l=8'hFE after line 0 fired → spike_out=8'h00, spike_count unchanged.
- Four valid steps with spike_valid gaps between them → REST lasts exactly 2 cycles, then done=1 for one cycle, fired=0, spike_count=0. A start during REST is ignored.
- All lines spiking, spike_in_l=8'h00, with FFI_MAX=8 → spike_out=8'hFF, spike_count=8 with no wrap.
